cobs_axis_decoder: RTL and testbench
====================================

# cobs_axis_decoder

Host-to-FPGA counterpart of the COBS packetizer on the USB path. Accepts a raw 8-bit AXI-Stream of COBS-encoded bytes, with frames delimited by `0x00`, from the FT232H receive side. Emits the decoded payload bytes as an 8-bit AXI-Stream, with `m_axis_tlast` on the final byte of each frame. Sits between the FT232H receive stream and the command/control consumers, in the `sys_clk` domain.

## Interface
Parameters: none. Data width is fixed at 8.

Ports:
- `clk`  in  1  system clock (`sys_clk`, 100 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `s_axis_tdata`  in  8  encoded byte.
- `s_axis_tvalid`  in  1  encoded byte valid.
- `s_axis_tready`  out  1  decoder accepts the encoded byte.
- `m_axis_tdata`  out  8  decoded byte.
- `m_axis_tvalid`  out  1  decoded byte valid.
- `m_axis_tready`  in  1  downstream accepts the decoded byte.
- `m_axis_tlast`  out  1  last decoded byte of the frame.
- `frame_error`  out  1  one-cycle pulse when a malformed frame is detected.

## Operation
- Internal state:
  - FSM `CODE` / `DATA`.
  - 8-bit `remaining` counter.
  - `prev_code_ff` flag: the previous group code was `0xFF`.
  - `first_group` flag.
  - Hold register H (data, valid).
  - Output register O (data, last, valid), which drives `m_*` directly.
- `CODE` state, input byte `b`:
  - `b == 0x00`: delimiter. If H is valid, move H to O with last=1 and clear H. Set `first_group`=1 and stay in `CODE`. A delimiter with H empty produces no output, so empty frames are dropped.
  - `b != 0x00`: if `!first_group && !prev_code_ff`, a decoded `0x00` is produced.
    - Then `remaining <= b-1`, `prev_code_ff <= (b==0xFF)`, `first_group <= 0`.
    - Go to `DATA` if `b > 1`, else stay in `CODE`.
- `DATA` state, input byte `b`:
  - `b != 0x00`: produce decoded `b` and decrement `remaining`. Return to `CODE` when `remaining` reaches 0.
  - `b == 0x00`: premature delimiter (malformed). Terminate the frame exactly as a delimiter in `CODE`, and raise `frame_error` for one cycle. Go to `CODE` with `first_group`=1.
- "Produce decoded d":
  - If H is valid, move H to O with last=0.
  - Then H <= d, valid.
- H exists because the last-ness of a byte is only known when the next encoded byte arrives. The implicit trailing zero of the final group is never emitted.
- `s_axis_tlast` is not present. The encoded input is a plain byte stream.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `frame_error` are 0.
  - H is invalid, FSM is in `CODE`, `first_group`=1.
  - `s_axis_tready` is 1.
- `s_axis_tready = !O.valid || m_axis_tready`, combinational. This holds even for input bytes that produce no output.
- O is loaded on the rising edge after the accepting beat.
- Latency: a decoded byte appears on `m_axis` one cycle after the encoded beat that follows it (next byte or delimiter).
- Sustained throughput is 1 byte/cycle when `m_axis_tready` is held high.
- O is held stable while `m_axis_tvalid && !m_axis_tready`. There is no combinational path from `m_axis_tready` to `m_axis_tdata`.
- Reset mid-frame discards H, O and the FSM state. No partial frame is emitted after reset.
- A group code of `0xFF` followed by a delimiter emits no trailing zero.
- A group code of `0x01` at the start of a frame produces no byte.

## Configuration
- `COBS_DECODER_ERROR_DETECT_EN` defined: `frame_error` pulses on a premature delimiter inside `DATA`, as specified above.
- `COBS_DECODER_ERROR_DETECT_EN` undefined: `frame_error` is tied to 0. A premature delimiter still terminates the frame with `m_axis_tlast` on the held byte, and decoding resumes at the next code byte.

## Test plan
- Basic frame: `03 11 22 02 33 00` with `m_axis_tready`=1 → `11 22 00 33`, `tlast` only on `33`, `frame_error` never asserted.
- Single zero payload: `01 01 00` → one byte `00` with `tlast`=1.
- Empty and idle frames: `00 00 01 00` → no `m_axis` beats, `s_axis_tready` stays 1.
- Maximum group: `FF`, then bytes `01..FE`, then `02 AA 00` → 254 bytes `01..FE` followed by `AA` with `tlast`, and no `00` between `FE` and `AA`.
- Backpressure: the basic frame stimulus with `m_axis_tready`=0 for 5 cycles after the first output beat → `s_axis_tready` drops while O is full, O is held stable, and the output sequence is identical with no loss or duplication.
- Malformed frame: `05 11 22 00` → `11 22` with `tlast` on `22`, and `frame_error` pulses for 1 cycle (it stays 0 with the macro undefined). A following `02 44 00` decodes to `44` with `tlast`.

Source files
------------

// File: rtl/cobs_axis_decoder.sv
// Streaming COBS decoder: 0x00-delimited encoded bytes in, decoded payload out with tlast per frame.
// Build with COBS_DECODER_ERROR_DETECT_EN defined to pulse frame_error on a premature delimiter.
//
// state   | meaning
// ST_CODE | expecting a group code byte or a frame delimiter
// ST_DATA | copying group data bytes, remaining_q of them still to come
module cobs_axis_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_error
);

  typedef enum logic {ST_CODE, ST_DATA} state_t;

  state_t     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic       prev_code_ff_q, prev_code_ff_d;
  logic       first_group_q, first_group_d;
  logic [7:0] h_data_q, h_data_d;
  logic       h_valid_q, h_valid_d;
  logic [7:0] o_data_q, o_data_d;
  logic       o_last_q, o_last_d;
  logic       o_valid_q, o_valid_d;
  logic       frame_error_q, frame_error_d;
  logic       accept, produce, end_frame;
  logic [7:0] produce_data;

  assign s_axis_tready = !o_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = o_data_q;
  assign m_axis_tvalid = o_valid_q;
  assign m_axis_tlast  = o_last_q;
  assign frame_error   = frame_error_q;

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    prev_code_ff_d = prev_code_ff_q;
    first_group_d  = first_group_q;
    h_data_d       = h_data_q;
    h_valid_d      = h_valid_q;
    o_data_d       = o_data_q;
    o_last_d       = o_last_q;
    o_valid_d      = o_valid_q;
    frame_error_d  = 1'b0;
    produce        = 1'b0;
    produce_data   = 8'h00;
    end_frame      = 1'b0;

    if (o_valid_q && m_axis_tready) o_valid_d = 1'b0;

    if (accept) begin
      if (state_q == ST_CODE) begin
        if (s_axis_tdata == 8'h00) begin
          end_frame = 1'b1;
        end else begin
          // Each code after the first stands for a zero, unless the previous group was a full 0xFF run
          if (!first_group_q && !prev_code_ff_q) produce = 1'b1;
          remaining_d    = s_axis_tdata - 8'd1;
          prev_code_ff_d = (s_axis_tdata == 8'hFF);
          first_group_d  = 1'b0;
          if (s_axis_tdata > 8'h01) state_d = ST_DATA;
        end
      end else begin
        if (s_axis_tdata == 8'h00) begin
          end_frame = 1'b1;
          state_d   = ST_CODE;
`ifdef COBS_DECODER_ERROR_DETECT_EN
          frame_error_d = 1'b1;
`endif
        end else begin
          produce      = 1'b1;
          produce_data = s_axis_tdata;
          remaining_d  = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = ST_CODE;
        end
      end
    end

    // H holds the newest decoded byte until we learn whether it ends the frame
    if (end_frame) begin
      first_group_d = 1'b1;
      if (h_valid_q) begin
        o_data_d  = h_data_q;
        o_last_d  = 1'b1;
        o_valid_d = 1'b1;
        h_valid_d = 1'b0;
      end
    end

    if (produce) begin
      if (h_valid_q) begin
        o_data_d  = h_data_q;
        o_last_d  = 1'b0;
        o_valid_d = 1'b1;
      end
      h_data_d  = produce_data;
      h_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_CODE;
      remaining_q    <= 8'h00;
      prev_code_ff_q <= 1'b0;
      first_group_q  <= 1'b1;
      h_data_q       <= 8'h00;
      h_valid_q      <= 1'b0;
      o_data_q       <= 8'h00;
      o_last_q       <= 1'b0;
      o_valid_q      <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      prev_code_ff_q <= prev_code_ff_d;
      first_group_q  <= first_group_d;
      h_data_q       <= h_data_d;
      h_valid_q      <= h_valid_d;
      o_data_q       <= o_data_d;
      o_last_q       <= o_last_d;
      o_valid_q      <= o_valid_d;
      frame_error_q  <= frame_error_d;
    end
  end

endmodule

// File: tb/tb_cobs_axis_decoder.sv
// Directed bench for cobs_axis_decoder: frame vector table plus max-group, backpressure and mid-frame reset sequences.
module tb_cobs_axis_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       frame_error;

`ifdef COBS_DECODER_ERROR_DETECT_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  cobs_axis_decoder dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Output monitor: sink with optional stall window, hold checks, error pulse counting
  logic [8:0] got_q[$];
  int         err_cnt = 0;
  logic       err_prev = 1'b0;
  int         stall_cnt = 0;
  int         stall_seen = 0;
  bit         bp_arm = 1'b0;
  logic       held_v = 1'b0;
  logic [8:0] held = 9'h0;

  always @(negedge clk) begin
    if (stall_cnt > 0) begin
      m_axis_tready = 1'b0;
      stall_cnt--;
    end else begin
      m_axis_tready = 1'b1;
    end
    #1;
    if (m_axis_tvalid && !m_axis_tready) begin
      stall_seen++;
      chk("s_tready_under_bp", s_axis_tready, 0);
      if (held_v) chk("o_held_stable", {m_axis_tlast, m_axis_tdata}, held);
      held_v = 1'b1;
      held   = {m_axis_tlast, m_axis_tdata};
    end else begin
      held_v = 1'b0;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back({m_axis_tlast, m_axis_tdata});
      if (bp_arm) begin
        bp_arm    = 1'b0;
        stall_cnt = 5;
      end
    end
    if (frame_error) begin
      err_cnt++;
      chk("frame_error_width", err_prev, 0);
    end
    err_prev = frame_error;
  end

  // Called at negedge+2; returns at the next negedge+2 once the byte is accepted
  task automatic send(input logic [7:0] b);
    int n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 50) chk("s_tready_timeout", s_axis_tready, 1);
    @(negedge clk);
    #2;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain_check(input string tag, input logic [63:0] dec, input int n_dec, input int n_err);
    repeat (4) @(negedge clk);
    #2;
    chk({tag, "_beats"}, got_q.size(), n_dec);
    for (int i = 0; i < n_dec && i < got_q.size(); i++) begin
      chk({tag, "_byte"}, got_q[i][7:0], dec[63-8*i -: 8]);
      chk({tag, "_last"}, got_q[i][8], (i == n_dec - 1) ? 1 : 0);
    end
    chk({tag, "_err"}, err_cnt, n_err);
    chk({tag, "_tready_idle"}, s_axis_tready, 1);
    got_q.delete();
    err_cnt = 0;
  endtask

  typedef struct packed {
    logic [63:0] enc;
    int          n_enc;
    logic [63:0] dec;
    int          n_dec;
    int          n_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{enc: 64'h0311_2202_3300_0000, n_enc: 6, dec: 64'h1122_0033_0000_0000, n_dec: 4, n_err: 0};
    vecs[1] = '{enc: 64'h0101_0000_0000_0000, n_enc: 3, dec: 64'h0000_0000_0000_0000, n_dec: 1, n_err: 0};
    vecs[2] = '{enc: 64'h0000_0100_0000_0000, n_enc: 4, dec: 64'h0000_0000_0000_0000, n_dec: 0, n_err: 0};
    vecs[3] = '{enc: 64'h0511_2200_0000_0000, n_enc: 4, dec: 64'h1122_0000_0000_0000, n_dec: 2, n_err: ERR_EXP};
    vecs[4] = '{enc: 64'h0244_0000_0000_0000, n_enc: 3, dec: 64'h4400_0000_0000_0000, n_dec: 1, n_err: 0};
    vecs[5] = '{enc: 64'h0211_0322_3300_0000, n_enc: 6, dec: 64'h1100_2233_0000_0000, n_dec: 4, n_err: 0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    rst = 1'b0;
    #1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n_enc; i++) send(vecs[v].enc[63-8*i -: 8]);
      drain_check($sformatf("vec%0d", v), vecs[v].dec, vecs[v].n_dec, vecs[v].n_err);
    end

    // Maximum-length group: no implied zero between FE and AA
    send(8'hFF);
    for (int i = 1; i <= 254; i++) send(i[7:0]);
    send(8'h02);
    send(8'hAA);
    send(8'h00);
    repeat (4) @(negedge clk);
    #2;
    chk("maxgrp_beats", got_q.size(), 255);
    if (got_q.size() == 255) begin
      for (int i = 0; i < 254; i++) chk("maxgrp_byte", got_q[i], {1'b0, 8'(i + 1)});
      chk("maxgrp_tail", got_q[254], 9'h1AA);
    end
    got_q.delete();
    err_cnt = 0;

    // Backpressure: 5 stall cycles right after the first output beat
    stall_seen = 0;
    bp_arm = 1'b1;
    for (int i = 0; i < vecs[0].n_enc; i++) send(vecs[0].enc[63-8*i -: 8]);
    drain_check("bp", vecs[0].dec, vecs[0].n_dec, 0);
    chk("bp_stall_cycles", stall_seen, 5);

    // Reset mid-frame: held byte must not leak into the next frame
    send(8'h03);
    send(8'h11);
    send(8'h22);
    rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", m_axis_tvalid, 0);
    chk("midrst_s_tready", s_axis_tready, 1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    got_q.delete();
    err_cnt = 0;
    send(8'h02);
    send(8'h55);
    send(8'h00);
    drain_check("midrst", 64'h5500_0000_0000_0000, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
